eh2_exu_bp_update_queue: RTL and testbench

- Sits directly downstream of the two EXU ALU pipes (I0, I1).
- Captures each resolved branch outcome (actual-taken, mispredict, new 2-bit history, predictor index/way, thread) the ALUs produce.
- Buffers these in a small in-order FIFO and drains them, one per cycle, to the IFU branch-predictor update port over a valid/ready handshake.
- Decouples ALU resolution timing from BHT/BTB write-port availability.

---
 rtl/eh2_pkg.sv | 15 +
 rtl/eh2_exu_bp_upd_ctl.sv | 70 +++++++
 rtl/eh2_exu_bp_update_queue.sv | 106 ++++++++++
 tb/tb_eh2_exu_bp_update_queue.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/eh2_pkg.sv
// Shared EH2 types: the branch-predictor update packet passed from the EXU to the IFU update port.
package eh2_pkg;

   localparam int BP_IDX_W = 8;

   typedef struct packed {
      logic                tid;
      logic                ataken;
      logic                misp;
      logic [1:0]          hist;
      logic                way;
      logic [BP_IDX_W-1:0] index;
   } eh2_bp_upd_pkt_t;

endpackage

// File: rtl/eh2_exu_bp_upd_ctl.sv
// Control for the branch-update queue: pointers, occupancy, space check and drop counting.
module eh2_exu_bp_upd_ctl #(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             i0_acc,
   input  logic             i1_acc,
   input  logic             pop,
   output logic             i0_we,
   output logic             i1_we,
   output logic [PTR_W-1:0] i0_wptr,
   output logic [PTR_W-1:0] i1_wptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [CNT_W-1:0] count,
   output logic             almost_full,
   output logic [7:0]       drop_cnt
);

   logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
   logic [CNT_W-1:0] count_r, count_nxt_s;
   logic [CNT_W:0]   space_s;
   logic             i0_push_s, i1_push_s, af_r, af_nxt_s;
   logic [1:0]       drops_s;
   logic [8:0]       drop_sum_s;
   logic [7:0]       drop_cnt_r, drop_nxt_s;

   // Space includes the slot freed by a same-cycle pop; I0 always claims space first.
   always_comb begin
      space_s      = (CNT_W+1)'(DEPTH) - {1'b0, count_r} + {{CNT_W{1'b0}}, pop};
      i0_push_s    = i0_acc & (space_s != {(CNT_W+1){1'b0}});
      i1_push_s    = i1_acc & (space_s > {{CNT_W{1'b0}}, i0_push_s});
      drops_s      = {1'b0, i0_acc & ~i0_push_s} + {1'b0, i1_acc & ~i1_push_s};
      count_nxt_s  = count_r + CNT_W'(i0_push_s) + CNT_W'(i1_push_s) - CNT_W'(pop);
      wr_ptr_nxt_s = wr_ptr_r + PTR_W'(i0_push_s) + PTR_W'(i1_push_s);
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(pop);
      drop_sum_s   = {1'b0, drop_cnt_r} + {7'b0000000, drops_s};
      drop_nxt_s   = drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
      af_nxt_s     = (count_nxt_s >= CNT_W'(DEPTH - 1));
   end

   // Occupancy state and the registered status outputs.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= {CNT_W{1'b0}};
         drop_cnt_r <= 8'h00;
         af_r       <= 1'b0;
      end else begin
         wr_ptr_r   <= wr_ptr_nxt_s;
         rd_ptr_r   <= rd_ptr_nxt_s;
         count_r    <= count_nxt_s;
         drop_cnt_r <= drop_nxt_s;
         af_r       <= af_nxt_s;
      end
   end

   assign i0_we       = i0_push_s;
   assign i1_we       = i1_push_s;
   assign i0_wptr     = wr_ptr_r;
   assign i1_wptr     = wr_ptr_r + PTR_W'(i0_push_s);
   assign rd_ptr      = rd_ptr_r;
   assign count       = count_r;
   assign almost_full = af_r;
   assign drop_cnt    = drop_cnt_r;

endmodule

// File: rtl/eh2_exu_bp_update_queue.sv
// In-order FIFO of resolved branch outcomes from the two ALU pipes, drained one per cycle to the IFU.
module eh2_exu_bp_update_queue
   import eh2_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int IDX_W       = BP_IDX_W,
   parameter int NUM_THREADS = 2
) (
   input  logic                   clk,
   input  logic                   rst_l,
   input  logic [NUM_THREADS-1:0] flush,
   input  logic                   i0_valid,
   input  logic                   i0_tid,
   input  logic                   i0_ataken,
   input  logic                   i0_misp,
   input  logic [1:0]             i0_hist,
   input  logic                   i0_way,
   input  logic [IDX_W-1:0]       i0_index,
   input  logic                   i1_valid,
   input  logic                   i1_tid,
   input  logic                   i1_ataken,
   input  logic                   i1_misp,
   input  logic [1:0]             i1_hist,
   input  logic                   i1_way,
   input  logic [IDX_W-1:0]       i1_index,
   output logic                   upd_valid,
   input  logic                   upd_ready,
   output logic                   upd_tid,
   output logic                   upd_ataken,
   output logic                   upd_misp,
   output logic [1:0]             upd_hist,
   output logic                   upd_way,
   output logic [IDX_W-1:0]       upd_index,
   output logic                   almost_full,
   output logic [7:0]             drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic             i0_flush_s, i1_flush_s, i0_tid_s, i1_tid_s;
   logic             i0_acc_s, i1_acc_s, pop_s, i0_we_s, i1_we_s;
   logic [PTR_W-1:0] i0_wptr_s, i1_wptr_s, rd_ptr_s;
   logic [CNT_W-1:0] count_s;
   eh2_bp_upd_pkt_t  i0_pkt_s, i1_pkt_s, head_s;
   eh2_bp_upd_pkt_t  mem_r [DEPTH];

   // Single-thread builds ignore tid and use flush[0] for both pipes.
   if (NUM_THREADS == 1) begin : g_st
      assign i0_flush_s = flush[0];
      assign i1_flush_s = flush[0];
      assign i0_tid_s   = 1'b0;
      assign i1_tid_s   = 1'b0;
   end else begin : g_mt
      assign i0_flush_s = flush[i0_tid];
      assign i1_flush_s = flush[i1_tid];
      assign i0_tid_s   = i0_tid;
      assign i1_tid_s   = i1_tid;
   end

   assign i0_acc_s  = i0_valid & ~i0_flush_s;
   assign i1_acc_s  = i1_valid & ~i1_flush_s;
   assign upd_valid = (count_s != {CNT_W{1'b0}});
   assign pop_s     = upd_valid & upd_ready;

   assign i0_pkt_s = '{tid: i0_tid_s, ataken: i0_ataken, misp: i0_misp, hist: i0_hist, way: i0_way, index: i0_index};
   assign i1_pkt_s = '{tid: i1_tid_s, ataken: i1_ataken, misp: i1_misp, hist: i1_hist, way: i1_way, index: i1_index};

   eh2_exu_bp_upd_ctl #(.DEPTH(DEPTH)) u_ctl (
      .clk         (clk),
      .rst_l       (rst_l),
      .i0_acc      (i0_acc_s),
      .i1_acc      (i1_acc_s),
      .pop         (pop_s),
      .i0_we       (i0_we_s),
      .i1_we       (i1_we_s),
      .i0_wptr     (i0_wptr_s),
      .i1_wptr     (i1_wptr_s),
      .rd_ptr      (rd_ptr_s),
      .count       (count_s),
      .almost_full (almost_full),
      .drop_cnt    (drop_cnt)
   );

   // Payload storage: per-entry enabled flops, deliberately not reset.
   always_ff @(posedge clk) begin
      for (int e = 0; e < DEPTH; e++) begin
         if (i0_we_s && (i0_wptr_s == PTR_W'(e))) begin
            mem_r[e] <= i0_pkt_s;
         end else if (i1_we_s && (i1_wptr_s == PTR_W'(e))) begin
            mem_r[e] <= i1_pkt_s;
         end else begin
            mem_r[e] <= mem_r[e];
         end
      end
   end

   assign head_s     = mem_r[rd_ptr_s];
   assign upd_tid    = upd_valid ? head_s.tid    : 1'b0;
   assign upd_ataken = upd_valid ? head_s.ataken : 1'b0;
   assign upd_misp   = upd_valid ? head_s.misp   : 1'b0;
   assign upd_hist   = upd_valid ? head_s.hist   : 2'b00;
   assign upd_way    = upd_valid ? head_s.way    : 1'b0;
   assign upd_index  = upd_valid ? head_s.index  : {IDX_W{1'b0}};

endmodule

// File: tb/tb_eh2_exu_bp_update_queue.sv
// Directed bench for eh2_exu_bp_update_queue with hand-computed expectations.
module tb_eh2_exu_bp_update_queue;

   logic       clk, rst_l;
   logic [1:0] flush;
   logic       i0_valid, i0_tid, i0_ataken, i0_misp, i0_way;
   logic [1:0] i0_hist;
   logic [7:0] i0_index;
   logic       i1_valid, i1_tid, i1_ataken, i1_misp, i1_way;
   logic [1:0] i1_hist;
   logic [7:0] i1_index;
   logic       upd_valid, upd_ready, upd_tid, upd_ataken, upd_misp, upd_way, almost_full;
   logic [1:0] upd_hist;
   logic [7:0] upd_index, drop_cnt;

   int vectors = 0;
   int miscompares = 0;

   eh2_exu_bp_update_queue #(.DEPTH(4), .IDX_W(8), .NUM_THREADS(2)) dut (
      .clk(clk), .rst_l(rst_l), .flush(flush),
      .i0_valid(i0_valid), .i0_tid(i0_tid), .i0_ataken(i0_ataken), .i0_misp(i0_misp),
      .i0_hist(i0_hist), .i0_way(i0_way), .i0_index(i0_index),
      .i1_valid(i1_valid), .i1_tid(i1_tid), .i1_ataken(i1_ataken), .i1_misp(i1_misp),
      .i1_hist(i1_hist), .i1_way(i1_way), .i1_index(i1_index),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_tid(upd_tid), .upd_ataken(upd_ataken),
      .upd_misp(upd_misp), .upd_hist(upd_hist), .upd_way(upd_way), .upd_index(upd_index),
      .almost_full(almost_full), .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      flush = 2'b00;
      i0_valid = 1'b0; i0_tid = 1'b0; i0_ataken = 1'b0; i0_misp = 1'b0;
      i0_hist = 2'b00; i0_way = 1'b0; i0_index = 8'h00;
      i1_valid = 1'b0; i1_tid = 1'b0; i1_ataken = 1'b0; i1_misp = 1'b0;
      i1_hist = 2'b00; i1_way = 1'b0; i1_index = 8'h00;
   endtask

   task automatic drive0(input logic [7:0] idx);
      i0_valid = 1'b1; i0_tid = 1'b0; i0_index = idx;
   endtask

   task automatic drive1(input logic [7:0] idx, input logic tid);
      i1_valid = 1'b1; i1_tid = tid; i1_index = idx;
   endtask

   initial begin
      clr_in();
      upd_ready = 1'b0;
      rst_l = 1'b1;
      #1 rst_l = 1'b0;
      step();
      step();
      chk("rst_valid", 32'(upd_valid), 32'd0);
      chk("rst_af", 32'(almost_full), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_index", 32'(upd_index), 32'd0);
      #2 rst_l = 1'b1;
      step();

      // 1: single push, seen the next cycle, popped immediately
      drive0(8'h3C); i0_hist = 2'b10; i0_ataken = 1'b1; upd_ready = 1'b1;
      step(); clr_in();
      chk("t1_valid", 32'(upd_valid), 32'd1);
      chk("t1_index", 32'(upd_index), 32'h3C);
      chk("t1_hist", 32'(upd_hist), 32'd2);
      chk("t1_ataken", 32'(upd_ataken), 32'd1);
      step();
      chk("t1_empty", 32'(upd_valid), 32'd0);
      chk("t1_zero_idx", 32'(upd_index), 32'd0);

      // 2: dual push, hold while not ready, then ordered drain
      upd_ready = 1'b0;
      drive0(8'h01); drive1(8'h02, 1'b0);
      step(); clr_in();
      for (int k = 0; k < 3; k++) begin
         chk("t2_hold", 32'(upd_index), 32'h01);
         if (k < 2) step();
      end
      upd_ready = 1'b1;
      step();
      chk("t2_second", 32'(upd_index), 32'h02);
      step();
      chk("t2_empty", 32'(upd_valid), 32'd0);
      upd_ready = 1'b0;

      // 3: fill, almost_full, single and dual drops when full
      drive0(8'h10); step(); chk("t3_af1", 32'(almost_full), 32'd0);
      drive0(8'h11); step(); chk("t3_af2", 32'(almost_full), 32'd0);
      drive0(8'h12); step(); chk("t3_af3", 32'(almost_full), 32'd1);
      drive0(8'h13); step(); chk("t3_af4", 32'(almost_full), 32'd1);
      chk("t3_nodrop", 32'(drop_cnt), 32'd0);
      drive0(8'h14); step();
      chk("t3_drop1", 32'(drop_cnt), 32'd1);
      drive0(8'h15); drive1(8'h16, 1'b0); step(); clr_in();
      chk("t3_drop3", 32'(drop_cnt), 32'd3);
      chk("t3_head", 32'(upd_index), 32'h10);

      // 4: count=3 with pop plus two accepts in the same cycle
      upd_ready = 1'b1;
      step();
      chk("t4_head", 32'(upd_index), 32'h11);
      drive0(8'h20); drive1(8'h21, 1'b1);
      step(); clr_in();
      chk("t4_nodrop", 32'(drop_cnt), 32'd3);
      chk("t4_af", 32'(almost_full), 32'd1);
      chk("t4_d0", 32'(upd_index), 32'h12); step();
      chk("t4_d1", 32'(upd_index), 32'h13); step();
      chk("t4_d2", 32'(upd_index), 32'h20); step();
      chk("t4_d3", 32'(upd_index), 32'h21);
      chk("t4_d3tid", 32'(upd_tid), 32'd1); step();
      chk("t4_empty", 32'(upd_valid), 32'd0);
      chk("t4_af0", 32'(almost_full), 32'd0);

      // 5: flushed inputs discarded, queued entries survive a flush
      upd_ready = 1'b0;
      drive0(8'h30); drive1(8'h31, 1'b1); flush = 2'b10;
      step(); clr_in();
      chk("t5_head", 32'(upd_index), 32'h30);
      chk("t5_tid", 32'(upd_tid), 32'd0);
      chk("t5_drop", 32'(drop_cnt), 32'd3);
      drive0(8'h32); flush = 2'b01;
      step(); clr_in();
      chk("t5_kept", 32'(upd_index), 32'h30);
      chk("t5_drop2", 32'(drop_cnt), 32'd3);
      upd_ready = 1'b1;
      step();
      chk("t5_one_only", 32'(upd_valid), 32'd0);
      drive1(8'h40, 1'b1); i1_misp = 1'b1; i1_way = 1'b1;
      step(); clr_in();
      chk("t5_i1_idx", 32'(upd_index), 32'h40);
      chk("t5_i1_tid", 32'(upd_tid), 32'd1);
      chk("t5_i1_misp", 32'(upd_misp), 32'd1);
      chk("t5_i1_way", 32'(upd_way), 32'd1);
      step();
      chk("t5_empty", 32'(upd_valid), 32'd0);

      // 6: drop_cnt saturation, then asynchronous reset mid-operation
      upd_ready = 1'b0;
      drive0(8'h50); drive1(8'h51, 1'b0); step();
      drive0(8'h52); drive1(8'h53, 1'b0); step();
      for (int k = 0; k < 130; k++) begin
         drive0(8'h60); drive1(8'h61, 1'b0); step();
      end
      clr_in();
      chk("t6_sat", 32'(drop_cnt), 32'hFF);
      upd_ready = 1'b1;
      step();
      upd_ready = 1'b0;
      chk("t6_head", 32'(upd_index), 32'h51);
      chk("t6_af", 32'(almost_full), 32'd1);
      #2 rst_l = 1'b0;
      #1;
      chk("t6_async_valid", 32'(upd_valid), 32'd0);
      chk("t6_async_af", 32'(almost_full), 32'd0);
      chk("t6_async_drop", 32'(drop_cnt), 32'd0);
      #2 rst_l = 1'b1;
      step();
      chk("t6_post_valid", 32'(upd_valid), 32'd0);
      chk("t6_post_drop", 32'(drop_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
